// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer.
// Picks the next instruction address each cycle from the decoder's branch
// request and the branch-LUT target word: sequential increment, absolute
// jump, or two's-complement relative jump. Also provides start/halt control,
// stall, a saturating RUN-cycle counter and a sticky address-wrap flag.
module pc_sequencer #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          AbsJump,
  input  logic [D-1:0]  Target,
  output logic [D-1:0]  ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCnt,
  output logic          WrapErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [D-1:0]  pc;
  logic [D-1:0]  pc_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wrap;
  logic          wrap_next;
  logic [D:0]    sum;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
      wrap  <= wrap_next;
    end
  end

  // Next state, next PC, counter and wrap flag; Start > Halt > Stall > BranchEn > increment.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;
    wrap_next  = wrap;
    sum        = '0;
    case (state)
      IDLE: begin
        pc_next = '0;
        if (Start) begin
          state_next = RUN;
          cnt_next   = '0;
          wrap_next  = 1'b0;
        end
      end
      RUN: begin
        if (cnt != {CW{1'b1}}) begin
          cnt_next = cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        if (Start) begin
          pc_next   = '0;
          cnt_next  = '0;
          wrap_next = 1'b0;
        end else if (Halt) begin
          state_next = HALTED;
        end else if (Stall) begin
          pc_next = pc;
        end else if (BranchEn) begin
          if (AbsJump) begin
            pc_next = Target;
          end else begin
            sum     = {1'b0, pc} + {1'b0, Target};
            pc_next = sum[D-1:0];
            // A negative offset borrows exactly when the unsigned add does not carry.
            if (Target[D-1] ? ~sum[D] : sum[D]) begin
              wrap_next = 1'b1;
            end
          end
        end else begin
          sum     = {1'b0, pc} + {{D{1'b0}}, 1'b1};
          pc_next = sum[D-1:0];
          if (sum[D]) begin
            wrap_next = 1'b1;
          end
        end
      end
      HALTED: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = '0;
          cnt_next   = '0;
          wrap_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  // Outputs come straight from registers so no input reaches an output combinationally.
  always_comb begin
    ProgCtr  = pc;
    Running  = (state == RUN);
    Done     = (state == HALTED);
    CycleCnt = cnt;
    WrapErr  = wrap;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard testbench for pc_sequencer: the stimulus process queues the
// hand-computed expected outputs, a separate monitor pops and compares them.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        Stall;
  logic        BranchEn;
  logic        AbsJump;
  logic [11:0] Target;
  logic [11:0] ProgCtr;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCnt;
  logic        WrapErr;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  event sample_now;
  int   nChecks = 0;
  int   nFails  = 0;

  pc_sequencer #(.D(12), .CW(16)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Halt     (Halt),
    .Stall    (Stall),
    .BranchEn (BranchEn),
    .AbsJump  (AbsJump),
    .Target   (Target),
    .ProgCtr  (ProgCtr),
    .Running  (Running),
    .Done     (Done),
    .CycleCnt (CycleCnt),
    .WrapErr  (WrapErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic exp_t mk(string n, logic [11:0] pc, logic run, logic done,
                              logic [15:0] cnt, logic wrap);
    exp_t e;
    e.name = n;
    e.pc   = pc;
    e.run  = run;
    e.done = done;
    e.cnt  = cnt;
    e.wrap = wrap;
    return e;
  endfunction

  task automatic cmp(string tag, string fld, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", tag, fld, act, exp);
    end
  endtask

  task automatic checkOutput(exp_t e);
    cmp(e.name, "ProgCtr",  {20'd0, ProgCtr},  {20'd0, e.pc});
    cmp(e.name, "Running",  {31'd0, Running},  {31'd0, e.run});
    cmp(e.name, "Done",     {31'd0, Done},     {31'd0, e.done});
    cmp(e.name, "CycleCnt", {16'd0, CycleCnt}, {16'd0, e.cnt});
    cmp(e.name, "WrapErr",  {31'd0, WrapErr},  {31'd0, e.wrap});
  endtask

  // Monitor: drains the scoreboard away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk or sample_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Drive one cycle of inputs from a falling edge and queue the outputs expected after the next rising edge.
  task automatic applyStimulus(string n, logic st, logic hl, logic sl, logic br, logic ab,
                               logic [11:0] tgt, logic [11:0] pc, logic run, logic done,
                               logic [15:0] cnt, logic wrap, bit chk = 1'b1);
    Start    = st;
    Halt     = hl;
    Stall    = sl;
    BranchEn = br;
    AbsJump  = ab;
    Target   = (br || sl) ? tgt : 12'hxxx;
    @(posedge Clk);
    if (chk) sb.push_back(mk(n, pc, run, done, cnt, wrap));
    @(negedge Clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
    BranchEn = 1'b0; AbsJump = 1'b0; Target = 12'h000;
    #3;
    sb.push_back(mk("reset", 12'h000, 1'b0, 1'b0, 16'd0, 1'b0));
    -> sample_now;
    @(negedge Clk);
    Reset = 1'b0;

    // IDLE ignores everything but Start
    applyStimulus("idle_br",   0, 0, 0, 1, 1, 12'd100, 12'd0, 0, 0, 16'd0, 0);
    applyStimulus("idle_halt", 0, 1, 1, 0, 0, 12'd0,   12'd0, 0, 0, 16'd0, 0);
    applyStimulus("start",     1, 0, 0, 0, 0, 12'd0,   12'd0, 1, 0, 16'd0, 0);
    for (int i = 1; i <= 5; i++)
      applyStimulus("inc", 0, 0, 0, 0, 0, 12'd0, 12'(i), 1, 0, 16'(i), 0);

    // Restart from RUN, then relative and absolute branches
    applyStimulus("restart_run", 1, 0, 0, 0, 0, 12'd0, 12'd0, 1, 0, 16'd0, 0);
    for (int i = 1; i <= 4; i++)
      applyStimulus("inc2", 0, 0, 0, 0, 0, 12'd0, 12'(i), 1, 0, 16'(i), 0);
    applyStimulus("rel_m1",  0, 0, 0, 1, 0, 12'hFFF, 12'd3,  1, 0, 16'd5, 0);
    applyStimulus("rel_p20", 0, 0, 0, 1, 0, 12'h014, 12'd23, 1, 0, 16'd6, 0);
    applyStimulus("abs_68",  0, 0, 0, 1, 1, 12'd68,  12'd68, 1, 0, 16'd7, 0);

    // Stall holds the PC and drops the concurrent branch
    applyStimulus("abs_7",     0, 0, 0, 1, 1, 12'd7,   12'd7,   1, 0, 16'd8,  0);
    applyStimulus("stall_br1", 0, 0, 1, 1, 1, 12'd300, 12'd7,   1, 0, 16'd9,  0);
    applyStimulus("stall_br2", 0, 0, 1, 1, 1, 12'd300, 12'd7,   1, 0, 16'd10, 0);
    applyStimulus("abs_300",   0, 0, 0, 1, 1, 12'd300, 12'd300, 1, 0, 16'd11, 0);

    // Sequential wrap sets the sticky flag
    applyStimulus("abs_ffe",  0, 0, 0, 1, 1, 12'hFFE, 12'hFFE, 1, 0, 16'd12, 0);
    applyStimulus("inc_fff",  0, 0, 0, 0, 0, 12'd0,   12'hFFF, 1, 0, 16'd13, 0);
    applyStimulus("inc_wrap", 0, 0, 0, 0, 0, 12'd0,   12'h000, 1, 0, 16'd14, 1);
    applyStimulus("inc_1",    0, 0, 0, 0, 0, 12'd0,   12'h001, 1, 0, 16'd15, 1);
    applyStimulus("inc_2",    0, 0, 0, 0, 0, 12'd0,   12'h002, 1, 0, 16'd16, 1);
    applyStimulus("rel_ffb",  0, 0, 0, 1, 0, 12'hFFB, 12'hFFD, 1, 0, 16'd17, 1);

    // Halt wins over branch; HALTED holds everything
    applyStimulus("abs_40",  0, 0, 0, 1, 1, 12'd40, 12'd40, 1, 0, 16'd18, 1);
    applyStimulus("halt_br", 0, 1, 0, 1, 1, 12'd5,  12'd40, 0, 1, 16'd19, 1);
    for (int i = 0; i < 10; i++)
      applyStimulus("halted_hold", 0, i[0], i[1], 1, i[2], 12'h123, 12'd40, 0, 1, 16'd19, 1);
    applyStimulus("start_halted", 1, 0, 0, 0, 0, 12'd0, 12'd0, 1, 0, 16'd0, 0);

    // Relative wrap: positive carry and negative borrow
    applyStimulus("abs_ff0",   0, 0, 0, 1, 1, 12'hFF0, 12'hFF0, 1, 0, 16'd1, 0);
    applyStimulus("rel_carry", 0, 0, 0, 1, 0, 12'h020, 12'h010, 1, 0, 16'd2, 1);
    applyStimulus("restart_a", 1, 0, 0, 0, 0, 12'd0,   12'd0,   1, 0, 16'd0, 0);
    applyStimulus("rel_borrow",0, 0, 0, 1, 0, 12'hFFF, 12'hFFF, 1, 0, 16'd1, 1);
    applyStimulus("start_halt",1, 1, 0, 0, 0, 12'd0,   12'd0,   1, 0, 16'd0, 0);
    applyStimulus("abs_55",    0, 0, 0, 1, 1, 12'd55,  12'd55,  1, 0, 16'd1, 0);

    // Asynchronous reset mid-cycle
    #2;
    Reset = 1'b1;
    #1;
    sb.push_back(mk("async_reset", 12'd0, 1'b0, 1'b0, 16'd0, 1'b0));
    -> sample_now;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus("post_reset_br", 0, 0, 0, 1, 1, 12'd99, 12'd0, 0, 0, 16'd0, 0);
    applyStimulus("start_again", 1, 0, 0, 0, 0, 12'd0, 12'd0, 1, 0, 16'd0, 0);
    applyStimulus("inc_again",   0, 0, 0, 0, 0, 12'd0, 12'd1, 1, 0, 16'd1, 0);

    // Cycle counter saturation
    applyStimulus("start_sat", 1, 0, 0, 0, 0, 12'd0, 12'd0, 1, 0, 16'd0, 0);
    for (int i = 1; i <= 65534; i++)
      applyStimulus("run", 0, 0, 0, 0, 0, 12'd0, 12'd0, 1, 0, 16'd0, 0, 1'b0);
    applyStimulus("sat_max",  0, 0, 0, 0, 0, 12'd0, 12'hFFF, 1, 0, 16'hFFFF, 1);
    applyStimulus("sat_hold", 0, 0, 0, 0, 0, 12'd0, 12'h000, 1, 0, 16'hFFFF, 1);

    @(negedge Clk);
    nChecks++;
    if (sb.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter / fetch sequencer; the consuming end of the branch-target lookup interface.
- Each cycle it takes the decoder's branch request and the D-bit target word from the branch LUT, and computes the next ProgCtr: sequential increment, absolute jump, or two's-complement relative jump.
- Adds start/halt control, stall, a cycle counter for benchmarking, and a sticky wrap error.
- Sits between the branch LUT/decoder and the instruction ROM address port.

Parameters:
- D, 12, width of ProgCtr and Target (instruction ROM address width).
- CW, 16, width of CycleCnt.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin or restart a program from address 0.
- Halt  input  1  decoder saw the halt/done instruction.
- Stall  input  1  hold ProgCtr this cycle.
- BranchEn  input  1  branch taken this cycle.
- AbsJump  input  1  1 = Target is an absolute address; 0 = Target is a signed offset.
- Target  input  D  word from the branch LUT.
- ProgCtr  output  D  current instruction address.
- Running  output  1  high in RUN state.
- Done  output  1  high in HALTED state.
- CycleCnt  output  CW  count of RUN cycles since last Start.
- WrapErr  output  1  sticky: sequential increment or relative add crossed the address space boundary.

Behaviour:
- Reset (async, any state, mid-program included): state=IDLE, ProgCtr=0, Running=0, Done=0, CycleCnt=0, WrapErr=0. Takes effect immediately, not at the next edge.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, HALTED.
- IDLE:
  - ProgCtr holds 0.
  - Start=1 -> RUN next cycle with ProgCtr=0, CycleCnt=0, WrapErr=0.
  - All other inputs are ignored.
- RUN:
  - Running=1. CycleCnt increments every cycle, including stall cycles, and saturates at all-ones.
  - Next-PC priority, highest first: Start > Halt > Stall > BranchEn > increment.
  - Start=1: ProgCtr=0, CycleCnt=0, WrapErr=0; stay in RUN.
  - Halt=1: go to HALTED; ProgCtr holds (it points at the halt instruction). CycleCnt counts this final cycle.
  - Stall=1: ProgCtr holds; BranchEn is ignored and is not remembered.
  - BranchEn=1, AbsJump=1: ProgCtr=Target.
  - BranchEn=1, AbsJump=0: ProgCtr=(ProgCtr+Target) mod 2^D, with Target treated as two's complement. Example with D=12: Target=12'hFFB means -5.
  - Otherwise: ProgCtr=(ProgCtr+1) mod 2^D.
- WrapErr (set in RUN, sticky until Reset or Start):
  - Increment from 2^D-1 wraps to 0 and sets WrapErr.
  - Relative add sets WrapErr on unsigned carry-out with a positive offset, or on borrow with a negative offset.
  - Absolute jumps never set it.
- HALTED:
  - Done=1, Running=0. ProgCtr and CycleCnt hold.
  - Start=1 -> RUN with ProgCtr=0, CycleCnt=0, WrapErr=0; Done drops on that edge.
  - Halt, Stall and BranchEn are ignored.
- Latency:
  - Start to first fetch of address 0 is 1 cycle.
  - A branch decision in cycle n gives the new ProgCtr in cycle n+1. There is no delay slot.
- Target is sampled only when BranchEn=1 and Stall=0; X on Target at other times must not propagate.

Test Plan:
- Reset, then Start pulse, no branches for 5 cycles -> ProgCtr 0,1,2,3,4,5; Running=1; CycleCnt=5.
- At PC=4, BranchEn=1, AbsJump=0, Target=12'hFFF -> PC=3. At PC=3, Target=12'h014 -> PC=23. At PC=23, BranchEn=1, AbsJump=1, Target=68 -> PC=68; WrapErr=0 throughout.
- At PC=7, Stall=1 together with BranchEn=1/Target=300 for 2 cycles -> PC stays 7 and CycleCnt still increments. Then BranchEn=1, Target=300, AbsJump=1 -> PC=300.
- Sequential wrap: AbsJump to 12'hFFE, then 2 increments -> PC=12'hFFF, then 0; WrapErr=1 and it stays set. Relative Target=12'hFFB at PC=2 -> PC=12'hFFD; WrapErr stays 1.
- Halt together with BranchEn at PC=40 -> Done=1, Running=0, PC=40 held for 10 cycles, CycleCnt frozen. Start -> PC=0, Done=0, CycleCnt=0, WrapErr=0.
- Reset asserted mid-RUN at PC=55, off-edge -> all outputs 0 immediately, state IDLE. Further BranchEn pulses are ignored until Start.
